// File: rtl/seg_scan_ctrl.sv
// 6-digit multiplexed 7-segment sequencer: handshake input, iterative double-dabble, atomic commit, prescaled scan.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_ctrl #(
  parameter int SCAN_DIV       = 69_444,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        val_valid,
  input  logic [19:0] val_data,
  output logic        val_ready,
  output logic        done,
  output logic        ovf,
  output logic [6:0]  seg,
  output logic [5:0]  sel
);

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  localparam logic [19:0] MAX_VAL   = 20'd999999;
  localparam logic [3:0]  DASH_CODE = 4'hA;
  localparam logic [23:0] DIV_M1    = 24'(SCAN_DIV - 1);
  localparam logic [6:0]  PAT_BLANK = 7'b1111111;

  function automatic logic [23:0] dd_adjust(input logic [23:0] b);
    logic [23:0] r;
    r = b;
    for (int i = 0; i < 6; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Active-low pattern; codes above 9 other than DASH render blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:      return 7'b1000000;
      4'd1:      return 7'b1111001;
      4'd2:      return 7'b0100100;
      4'd3:      return 7'b0110000;
      4'd4:      return 7'b0011001;
      4'd5:      return 7'b0010010;
      4'd6:      return 7'b0000010;
      4'd7:      return 7'b1111000;
      4'd8:      return 7'b0000000;
      4'd9:      return 7'b0010000;
      DASH_CODE: return 7'b0111111;
      default:   return PAT_BLANK;
    endcase
  endfunction

  function automatic logic [6:0] seg_polarity(input logic [6:0] p);
    return SEG_ACTIVE_LOW ? p : ~p;
  endfunction

`ifdef SEG_SCAN_LZB_EN
  // Digit k (k>=1) is blanked when it and every digit above it are zero.
  function automatic logic [5:0] lzb_mask(input logic [23:0] b);
    logic [5:0] m;
    logic       seen;
    m    = '0;
    seen = 1'b0;
    for (int i = 5; i >= 1; i--) begin
      if (b[4*i +: 4] != 4'd0) seen = 1'b1;
      m[i] = ~seen;
    end
    return m;
  endfunction

  logic [5:0] blank_q, blank_d;
`endif

  state_t      state_q, state_d;
  logic [19:0] bin_q, bin_d;
  logic [23:0] bcd_q, bcd_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [23:0] disp_q, disp_d;
  logic        ovf_q, ovf_d;
  logic [23:0] presc_q, presc_d;
  logic [2:0]  idx_q, idx_d;
  logic [5:0]  sel_q, sel_d;
  logic [6:0]  seg_q, seg_d;
  logic        tick;
  logic [6:0]  pat;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
`ifdef SEG_SCAN_LZB_EN
    blank_d = blank_q;
`endif
    case (state_q)
      IDLE: begin
        if (val_valid) begin
          if (val_data > MAX_VAL) begin
            ovf_d   = 1'b1;
            state_d = COMMIT;
          end else begin
            ovf_d   = 1'b0;
            bin_d   = val_data;
            bcd_d   = '0;
            cnt_d   = '0;
            state_d = CONV;
          end
        end
      end
      CONV: begin
        {bcd_d, bin_d} = {dd_adjust(bcd_q), bin_q} << 1;
        cnt_d          = cnt_q + 5'd1;
        if (cnt_q == 5'd19) state_d = COMMIT;
      end
      COMMIT: begin
        // The scanner reads disp_q, so a tick on this edge still shows the old value.
        disp_d  = ovf_q ? {6{DASH_CODE}} : bcd_q;
`ifdef SEG_SCAN_LZB_EN
        blank_d = ovf_q ? 6'b000000 : lzb_mask(bcd_q);
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tick    = (presc_q == DIV_M1);
    presc_d = tick ? 24'd0 : presc_q + 24'd1;
    idx_d   = idx_q;
    sel_d   = sel_q;
    seg_d   = seg_q;
    pat     = seg_decode(disp_q[{idx_q, 2'b00} +: 4]);
`ifdef SEG_SCAN_LZB_EN
    if (blank_q[idx_q]) pat = PAT_BLANK;
`endif
    if (tick) begin
      sel_d = ~(6'b000001 << idx_q);
      seg_d = seg_polarity(pat);
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
`ifdef SEG_SCAN_LZB_EN
      blank_q <= 6'b111110;
`endif
      presc_q <= '0;
      idx_q   <= '0;
      sel_q   <= 6'b111111;
      seg_q   <= seg_polarity(PAT_BLANK);
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
`ifdef SEG_SCAN_LZB_EN
      blank_q <= blank_d;
`endif
      presc_q <= presc_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
    end
  end

  assign val_ready = (state_q == IDLE);
  assign done      = (state_q == COMMIT);
  assign ovf       = ovf_q;
  assign seg       = seg_q;
  assign sel       = sel_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (SCAN_DIV=4) against a decimal-arithmetic display model.
module tb_seg_scan_ctrl;
  localparam int D = 4;

  logic        clk_in = 1'b0;
  logic        rst_n = 1'b0;
  logic        val_valid = 1'b0;
  logic [19:0] val_data = '0;
  logic        val_ready, done, ovf;
  logic [6:0]  seg;
  logic [5:0]  sel;

  int checks = 0;
  int failures = 0;
  int edge_cnt;
  int mdig[6];
  bit mblank[6];

  seg_scan_ctrl #(.SCAN_DIV(D), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .val_valid(val_valid), .val_data(val_data),
    .val_ready(val_ready), .done(done), .ovf(ovf), .seg(seg), .sel(sel)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  function automatic logic [6:0] exp_pat(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000;  10: return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  // Digit 10 stands for DASH.
  task automatic model_commit(input int v);
    int t;
    bit seen;
    t = v;
    for (int k = 0; k < 6; k++) begin
      mdig[k]   = (v > 999999) ? 10 : t % 10;
      t         = t / 10;
      mblank[k] = 1'b0;
    end
`ifdef SEG_SCAN_LZB_EN
    seen = 1'b0;
    if (v <= 999999) begin
      for (int k = 5; k >= 1; k--) begin
        if (mdig[k] != 0) seen = 1'b1;
        mblank[k] = !seen;
      end
    end
`else
    seen = 1'b0;
`endif
  endtask

  // Advance to the negedge following the next scan tick edge.
  task automatic wait_tick(output int idx, output bit ok);
    int n;
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while ((edge_cnt == 0 || edge_cnt % D != 0) && n < 100);
    ok  = (n < 100);
    idx = (edge_cnt / D - 1) % 6;
  endtask

  task automatic send_value(input int v, input bit hold5, output int lat, output int lat2,
                            output bit ovf_at_done, output bit rdy_busy);
    int n;
    lat = -1; lat2 = -1; ovf_at_done = 1'b0; rdy_busy = 1'b0;
    @(negedge clk_in);
    val_valid = 1'b1;
    val_data  = 20'(v);
    @(negedge clk_in);
    n = 1;
    if (hold5) val_data = 20'd5;
    else       val_valid = 1'b0;
    while (!done && n < 200) begin
      if (val_ready) rdy_busy = 1'b1;
      @(negedge clk_in);
      n++;
    end
    if (done) begin
      lat = n;
      ovf_at_done = ovf;
    end
    if (hold5) begin
      @(negedge clk_in);
      n++;
      while (!done && n < 200) begin
        @(negedge clk_in);
        n++;
      end
      if (done) lat2 = n;
      val_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    int idx;
    bit ok;
    logic [5:0] es;
    logic [6:0] eg;
    rst_n = 1'b0;
    model_commit(0);
    repeat (2) @(negedge clk_in);
    checks++;
    if (val_ready !== 1'b1 || done !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl ready=%b done=%b ovf=%b expected 1 0 0", val_ready, done, ovf);
    end
    checks++;
    if (sel !== 6'b111111 || seg !== 7'b1111111) begin
      failures++;
      $display("FAIL reset_scan sel=%b seg=%b expected 111111 1111111", sel, seg);
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk_in);
      checks++;
      if (sel !== 6'b111111) begin
        failures++;
        $display("FAIL pre_tick_sel cycle%0d sel=%b expected 111111", c, sel);
      end
    end
    @(negedge clk_in);
    checks++;
    if (sel !== 6'b111110 || seg !== 7'b1000000) begin
      failures++;
      $display("FAIL first_tick sel=%b seg=%b expected 111110 1000000", sel, seg);
    end
    for (int r = 0; r < 6; r++) begin
      wait_tick(idx, ok);
      es = ~(6'b000001 << idx);
      eg = mblank[idx] ? 7'b1111111 : exp_pat(mdig[idx]);
      checks++;
      if (!ok || sel !== es || seg !== eg) begin
        failures++;
        $display("FAIL reset_round digit%0d sel=%b seg=%b expected sel=%b seg=%b", idx, sel, seg, es, eg);
      end
    end
    checks++;
    if (sel !== 6'b111110) begin
      failures++;
      $display("FAIL wrap_to_digit0 sel=%b expected 111110", sel);
    end
  endtask

  task automatic test_convert();
    int vals[10];
    int lat, lat2, idx;
    bit ov, rb, ok;
    logic [5:0] es;
    logic [6:0] eg;
    vals[0] = 832040; vals[1] = 1000000; vals[2] = 0; vals[3] = 999999; vals[4] = 42;
    vals[5] = 1048575;
    for (int i = 6; i < 10; i++)
      vals[i] = (i % 2 == 1) ? int'($urandom_range(1048575, 1000000)) : int'($urandom_range(999999, 0));
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (val_ready !== 1'b1) begin
        failures++;
        $display("FAIL ready_before_accept value=%0d ready=%b expected 1", vals[i], val_ready);
      end
      send_value(vals[i], 1'b0, lat, lat2, ov, rb);
      model_commit(vals[i]);
      checks++;
      if (lat != ((vals[i] > 999999) ? 1 : 21)) begin
        failures++;
        $display("FAIL done_latency value=%0d got=%0d expected=%0d", vals[i], lat, (vals[i] > 999999) ? 1 : 21);
      end
      checks++;
      if (ov !== (vals[i] > 999999) || rb !== 1'b0) begin
        failures++;
        $display("FAIL ovf_ready value=%0d ovf=%b busy_ready=%b expected ovf=%b busy_ready=0",
                 vals[i], ov, rb, vals[i] > 999999);
      end
      @(negedge clk_in);
      checks++;
      if (val_ready !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL post_commit value=%0d ready=%b done=%b expected 1 0", vals[i], val_ready, done);
      end
      wait_tick(idx, ok);
      for (int r = 0; r < 6; r++) begin
        wait_tick(idx, ok);
        es = ~(6'b000001 << idx);
        eg = mblank[idx] ? 7'b1111111 : exp_pat(mdig[idx]);
        checks++;
        if (!ok || sel !== es || seg !== eg) begin
          failures++;
          $display("FAIL scan value=%0d digit%0d sel=%b seg=%b expected sel=%b seg=%b",
                   vals[i], idx, sel, seg, es, eg);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, lat2, idx, v;
    bit ov, rb, ok;
    logic [5:0] es;
    logic [6:0] eg;
    v = int'($urandom_range(999999, 100000));
    send_value(v, 1'b1, lat, lat2, ov, rb);
    checks++;
    if (lat != 21 || lat2 != 43 || rb !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back first_done=%0d second_done=%0d busy_ready=%b expected 21 43 0", lat, lat2, rb);
    end
    model_commit(5);
    wait_tick(idx, ok);
    for (int r = 0; r < 6; r++) begin
      wait_tick(idx, ok);
      es = ~(6'b000001 << idx);
      eg = mblank[idx] ? 7'b1111111 : exp_pat(mdig[idx]);
      checks++;
      if (!ok || sel !== es || seg !== eg) begin
        failures++;
        $display("FAIL held_value_scan digit%0d sel=%b seg=%b expected sel=%b seg=%b", idx, sel, seg, es, eg);
      end
    end
  endtask

  task automatic test_reset_midconv();
    int idx, dones;
    bit ok;
    logic [5:0] es;
    logic [6:0] eg;
    @(negedge clk_in);
    val_valid = 1'b1;
    val_data  = 20'd123456;
    @(negedge clk_in);
    val_valid = 1'b0;
    repeat (9) @(negedge clk_in);
    checks++;
    if (val_ready !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL midconv_state ready=%b done=%b expected 0 0", val_ready, done);
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if (val_ready !== 1'b1 || sel !== 6'b111111) begin
      failures++;
      $display("FAIL async_reset ready=%b sel=%b expected 1 111111", val_ready, sel);
    end
    @(negedge clk_in);
    rst_n = 1'b1;
    model_commit(0);
    dones = 0;
    repeat (30) begin
      @(negedge clk_in);
      if (done) dones++;
    end
    checks++;
    if (dones != 0 || val_ready !== 1'b1) begin
      failures++;
      $display("FAIL aborted_conv done_pulses=%0d ready=%b expected 0 1", dones, val_ready);
    end
    for (int r = 0; r < 6; r++) begin
      wait_tick(idx, ok);
      es = ~(6'b000001 << idx);
      eg = mblank[idx] ? 7'b1111111 : exp_pat(mdig[idx]);
      checks++;
      if (!ok || sel !== es || seg !== eg) begin
        failures++;
        $display("FAIL post_abort_scan digit%0d sel=%b seg=%b expected sel=%b seg=%b", idx, sel, seg, es, eg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_convert();
    test_back_to_back();
    test_reset_midconv();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
